// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: pipelined carry-lookahead adder/subtractor, one SLICE-bit slice per stage,
// with valid/ready streaming handshake and a single global advance enable.
module cla_pipe_adder #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NSTAGE = WIDTH / SLICE;
    localparam int NG = SLICE / BLOCK;

    logic en;
    logic ovf_r;
    logic             v  [NSTAGE];
    logic [WIDTH-1:0] ra [NSTAGE];
    logic [WIDTH-1:0] rb [NSTAGE];
    logic [WIDTH-1:0] rs [NSTAGE];
    logic             rc [NSTAGE];
    logic             nv [NSTAGE];
    logic [WIDTH-1:0] na [NSTAGE];
    logic [WIDTH-1:0] nb [NSTAGE];
    logic [WIDTH-1:0] ns [NSTAGE];
    logic [SLICE+1:0] r  [NSTAGE];

    // Returns {carry into slice MSB, slice carry out, slice sum}.
    function automatic logic [SLICE+1:0] slice_add(input logic [SLICE-1:0] x, input logic [SLICE-1:0] y,
                                                   input logic ci);
        logic [SLICE-1:0] p, g, s;
        logic cg, cm, c, t, gg, pp;
        p = x ^ y;
        g = x & y;
        s = '0;
        cg = ci;
        cm = ci;
        for (int q = 0; q < NG; q++) begin
            for (int j = 0; j < BLOCK; j++) begin
                c = cg;
                for (int m = 0; m < j; m++) c = c & p[q*BLOCK+m];
                for (int m = 0; m < j; m++) begin
                    t = g[q*BLOCK+m];
                    for (int n = m + 1; n < j; n++) t = t & p[q*BLOCK+n];
                    c = c | t;
                end
                s[q*BLOCK+j] = p[q*BLOCK+j] ^ c;
                cm = c;
            end
            gg = 1'b0;
            pp = 1'b1;
            for (int m = 0; m < BLOCK; m++) begin
                t = g[q*BLOCK+m];
                for (int n = m + 1; n < BLOCK; n++) t = t & p[q*BLOCK+n];
                gg = gg | t;
                pp = pp & p[q*BLOCK+m];
            end
            cg = gg | (pp & cg);
        end
        return {cm, cg, s};
    endfunction

    assign en        = out_ready | ~out_valid;
    assign in_ready  = en;
    assign out_valid = v[NSTAGE-1];
    assign sum       = rs[NSTAGE-1];
    assign cout      = rc[NSTAGE-1];
    assign ovf       = ovf_r;

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        logic [WIDTH-1:0] xs;
        logic xc;
        if (k == 0) begin : g_first
            assign nv[k] = in_valid;
            assign na[k] = a;
            assign nb[k] = sub ? ~b : b;
            assign xc    = sub | cin;
            assign xs    = '0;
        end else begin : g_next
            assign nv[k] = v[k-1];
            assign na[k] = ra[k-1];
            assign nb[k] = rb[k-1];
            assign xc    = rc[k-1];
            assign xs    = rs[k-1];
        end
        assign r[k] = slice_add(na[k][k*SLICE +: SLICE], nb[k][k*SLICE +: SLICE], xc);
        always_comb begin
            ns[k] = xs;
            ns[k][k*SLICE +: SLICE] = r[k][SLICE-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r <= 1'b0;
            for (int k = 0; k < NSTAGE; k++) begin
                v[k]  <= 1'b0;
                ra[k] <= '0;
                rb[k] <= '0;
                rs[k] <= '0;
                rc[k] <= 1'b0;
            end
        end else if (en) begin
            ovf_r <= r[NSTAGE-1][SLICE+1] ^ r[NSTAGE-1][SLICE];
            for (int k = 0; k < NSTAGE; k++) begin
                v[k]  <= nv[k];
                ra[k] <= na[k];
                rb[k] <= nb[k];
                rs[k] <= ns[k];
                rc[k] <= r[k][SLICE];
            end
        end
    end
endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb_cla_pipe_adder: directed and streaming checks of cla_pipe_adder, plus a
// parameter sweep over three extra configurations.
module tb_cla_pipe_adder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0, out_ready = 1'b0, cin = 1'b0, sub = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic in_ready, out_valid, cout, ovf;
    logic [31:0] sum;
    int checks = 0;
    int failures = 0;

    logic sw_valid = 1'b0, sw_cin = 1'b0, sw_sub = 1'b0, sw_ready = 1'b1;
    logic [63:0] sw_a = '0, sw_b = '0;
    logic ir8, ir16, ir64, v8, v16, v64, c8, c16, c64, o8, o16, o64;
    logic [7:0] s8;
    logic [15:0] s16;
    logic [63:0] s64;

    always #5 clk = ~clk;

    cla_pipe_adder dut (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf));
    cla_pipe_adder #(.WIDTH(8), .SLICE(8), .BLOCK(4)) d8 (.clk(clk), .rst_n(rst_n), .in_valid(sw_valid),
        .in_ready(ir8), .a(sw_a[7:0]), .b(sw_b[7:0]), .cin(sw_cin), .sub(sw_sub), .out_valid(v8),
        .out_ready(sw_ready), .sum(s8), .cout(c8), .ovf(o8));
    cla_pipe_adder #(.WIDTH(16), .SLICE(4), .BLOCK(4)) d16 (.clk(clk), .rst_n(rst_n), .in_valid(sw_valid),
        .in_ready(ir16), .a(sw_a[15:0]), .b(sw_b[15:0]), .cin(sw_cin), .sub(sw_sub), .out_valid(v16),
        .out_ready(sw_ready), .sum(s16), .cout(c16), .ovf(o16));
    cla_pipe_adder #(.WIDTH(64), .SLICE(16), .BLOCK(8)) d64 (.clk(clk), .rst_n(rst_n), .in_valid(sw_valid),
        .in_ready(ir64), .a(sw_a), .b(sw_b), .cin(sw_cin), .sub(sw_sub), .out_valid(v64),
        .out_ready(sw_ready), .sum(s64), .cout(c64), .ovf(o64));

    // Reference {ovf, cout, sum} for a w-bit add/subtract using plain integer arithmetic.
    function automatic logic [65:0] model(input logic [63:0] x, input logic [63:0] y, input logic ci,
                                          input logic sb, input int w);
        logic [64:0] m, f;
        logic [63:0] yy;
        m = (65'd1 << w) - 65'd1;
        yy = sb ? ~y : y;
        f = ({1'b0, x} & m) + ({1'b0, yy} & m) + {64'd0, sb | ci};
        return {(x[w-1] == yy[w-1]) && (f[w-1] != x[w-1]), f[w], f[63:0] & m[63:0]};
    endfunction

    task automatic run_beat(input logic [31:0] x, input logic [31:0] y, input logic ci, input logic sb,
                            output logic [31:0] s, output logic c, output logic o, output int lat);
        @(negedge clk);
        a = x; b = y; cin = ci; sub = sb; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 1;
        while (lat < 20) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
            lat++;
        end
        s = sum; c = cout; o = ovf;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #22;
        checks++;
        if ({out_valid, sum, cout, ovf, in_ready} !== {1'b0, 32'd0, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset_hold got v=%b sum=%h c=%b o=%b rdy=%b exp 0 0 0 0 1", out_valid, sum, cout, ovf, in_ready);
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({out_valid, sum, cout, ovf, in_ready} !== {1'b0, 32'd0, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset_idle got v=%b sum=%h c=%b o=%b rdy=%b exp 0 0 0 0 1", out_valid, sum, cout, ovf, in_ready);
        end
    endtask

    task automatic test_carry;
        logic [31:0] xa [2] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF};
        logic [31:0] xb [2] = '{32'h0, 32'h1};
        logic        xc [2] = '{1'b1, 1'b0};
        logic [31:0] es [2] = '{32'h0, 32'h8000_0000};
        logic        ec [2] = '{1'b1, 1'b0};
        logic        eo [2] = '{1'b0, 1'b1};
        logic [31:0] s;
        logic c, o;
        int lat;
        for (int i = 0; i < 2; i++) begin
            run_beat(xa[i], xb[i], xc[i], 1'b0, s, c, o, lat);
            checks++;
            if (lat !== 4) begin failures++; $display("FAIL carry%0d latency got %0d exp 4", i, lat); end
            checks++;
            if ({s, c, o} !== {es[i], ec[i], eo[i]}) begin
                failures++;
                $display("FAIL carry%0d result got %h c=%b o=%b exp %h c=%b o=%b", i, s, c, o, es[i], ec[i], eo[i]);
            end
        end
    endtask

    task automatic test_sub;
        logic [31:0] xa [3] = '{32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] xb [3] = '{32'd7, 32'h1, 32'h1};
        logic        xc [3] = '{1'b0, 1'b0, 1'b1};
        logic [31:0] es [3] = '{32'hFFFF_FFFE, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
        logic        ec [3] = '{1'b0, 1'b1, 1'b1};
        logic        eo [3] = '{1'b0, 1'b1, 1'b1};
        logic [31:0] s;
        logic c, o;
        int lat;
        for (int i = 0; i < 3; i++) begin
            run_beat(xa[i], xb[i], xc[i], 1'b1, s, c, o, lat);
            checks++;
            if ({s, c, o} !== {es[i], ec[i], eo[i]} || lat !== 4) begin
                failures++;
                $display("FAIL sub%0d got %h c=%b o=%b lat=%0d exp %h c=%b o=%b lat=4", i, s, c, o, lat, es[i], ec[i], eo[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] e;
        for (int j = 0; j <= 12; j++) begin
            @(negedge clk);
            if (j >= 4 && j <= 11) begin
                e = 32'(j - 4) - 32'd1;
                checks++;
                if (out_valid !== 1'b1 || sum !== e) begin
                    failures++;
                    $display("FAIL b2b beat%0d got v=%b sum=%h exp v=1 sum=%h", j - 4, out_valid, sum, e);
                end
            end else begin
                checks++;
                if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b idle%0d got v=%b exp 0", j, out_valid); end
            end
            in_valid = (j < 8);
            a = 32'(j); b = 32'hFFFF_FFFF; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_stream;
        logic [65:0] q [$];
        logic [65:0] e;
        logic hold = 1'b0;
        logic [32:0] hs = '0;
        int sent = 0, got = 0, cyc = 0;
        while (got < 100 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (hold) begin
                checks++;
                if (out_valid !== 1'b1 || {cout, sum} !== hs) begin
                    failures++;
                    $display("FAIL stall_hold got v=%b %h exp v=1 %h", out_valid, {cout, sum}, hs);
                end
            end
            out_ready = 1'($urandom_range(0, 1));
            in_valid = (sent < 100) && ($urandom_range(0, 1) == 1);
            a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (in_ready !== (out_ready | ~out_valid)) begin
                failures++;
                $display("FAIL in_ready got %b exp %b", in_ready, out_ready | ~out_valid);
            end
            if (in_valid && in_ready) begin
                q.push_back(model({32'd0, a}, {32'd0, b}, cin, sub, 32));
                sent++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL stream_extra got beat %h exp none", sum);
                end else begin
                    e = q.pop_front();
                    if ({ovf, cout, sum} !== {e[65], e[64], e[31:0]}) begin
                        failures++;
                        $display("FAIL stream%0d got o=%b c=%b %h exp o=%b c=%b %h", got, ovf, cout, sum, e[65], e[64], e[31:0]);
                    end
                end
                got++;
            end
            hold = out_valid && !out_ready;
            hs = {cout, sum};
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (got != 100 || sent != 100 || q.size() != 0) begin
            failures++;
            $display("FAIL stream_count got sent=%0d recv=%0d left=%0d exp 100 100 0", sent, got, q.size());
        end
    endtask

    task automatic test_reset_midflight;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a = 32'(i + 1); b = 32'd1000; cin = 1'b0; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL midrst_full got v=%b exp 1", out_valid); end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || sum !== 32'd0) begin
            failures++;
            $display("FAIL midrst_drop got v=%b sum=%h exp v=0 sum=0", out_valid, sum);
        end
        #1 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_ghost%0d got v=%b sum=%h exp v=0", i, out_valid, sum); end
        end
    endtask

    task automatic test_sweep;
        logic [63:0] va [8] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd5, 64'h8000_0000_0000_0000,
                                64'h8080_8080_8080_8080, 64'h0123_4567_89AB_CDEF, 64'd0, 64'hFFFF_0000_FFFF_0000};
        logic [63:0] vb [8] = '{64'd0, 64'd1, 64'd7, 64'd1, 64'h8080_8080_8080_8080, 64'hFEDC_BA98_7654_3210,
                                64'd0, 64'h0000_FFFF_0000_FFFF};
        logic        vc [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic        vs [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [65:0] e8, e16, e64;
        logic [9:0] g8;
        logic [17:0] g16;
        logic [65:0] g64;
        int l8, l16, l64;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            sw_a = (i < 8) ? va[i] : {$urandom, $urandom};
            sw_b = (i < 8) ? vb[i] : {$urandom, $urandom};
            sw_cin = (i < 8) ? vc[i] : 1'($urandom_range(0, 1));
            sw_sub = (i < 8) ? vs[i] : 1'($urandom_range(0, 1));
            sw_valid = 1'b1;
            e8 = model(sw_a, sw_b, sw_cin, sw_sub, 8);
            e16 = model(sw_a, sw_b, sw_cin, sw_sub, 16);
            e64 = model(sw_a, sw_b, sw_cin, sw_sub, 64);
            @(posedge clk);
            #1 sw_valid = 1'b0;
            l8 = 0; l16 = 0; l64 = 0;
            g8 = '0; g16 = '0; g64 = '0;
            for (int cyc = 1; cyc <= 6; cyc++) begin
                @(negedge clk);
                if (v8 && l8 == 0) begin l8 = cyc; g8 = {o8, c8, s8}; end
                if (v16 && l16 == 0) begin l16 = cyc; g16 = {o16, c16, s16}; end
                if (v64 && l64 == 0) begin l64 = cyc; g64 = {o64, c64, s64}; end
                if (cyc < 6) @(posedge clk);
            end
            checks++;
            if (l8 != 1 || g8 !== {e8[65:64], e8[7:0]}) begin
                failures++;
                $display("FAIL sweep8_%0d got lat=%0d %h exp lat=1 %h", i, l8, g8, {e8[65:64], e8[7:0]});
            end
            checks++;
            if (l16 != 4 || g16 !== {e16[65:64], e16[15:0]}) begin
                failures++;
                $display("FAIL sweep16_%0d got lat=%0d %h exp lat=4 %h", i, l16, g16, {e16[65:64], e16[15:0]});
            end
            checks++;
            if (l64 != 4 || g64 !== e64) begin
                failures++;
                $display("FAIL sweep64_%0d got lat=%0d %h exp lat=4 %h", i, l64, g64, e64);
            end
        end
    endtask

    initial begin
        test_reset();
        test_carry();
        test_sub();
        test_back_to_back();
        test_stream();
        test_reset_midflight();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
